// File: rtl/wheel_pkg.sv
// wheel_pkg: shared state encoding, widths and helpers for the wheel speed meter slice.
package wheel_pkg;

    localparam int COUNT_W = 8;

    // One millisecond gate window at a 50 MHz system clock.
    localparam int unsigned DEFAULT_WINDOW_CYCLES = 50000;

    typedef enum logic [1:0] {
        S_INIT,
        S_MEASURE,
        S_REPORT
    } wheel_state_e;

    // Window displacement, read as two's complement.
    typedef logic signed [COUNT_W-1:0] delta_t;

    // Magnitude of a signed delta; -128 maps to 128, which still fits the unsigned width.
    function automatic logic [COUNT_W-1:0] abs_mag(input delta_t d);
        delta_t neg;
        neg = -d;
        return d[COUNT_W-1] ? neg : d;
    endfunction

endpackage

// File: rtl/wheel_gate_timer.sv
// wheel_gate_timer: free-running gate window timer with a one-cycle terminal tick.
// Counts 0..WINDOW_CYCLES-1 while enabled, clears whenever enable is low.
module wheel_gate_timer
    import wheel_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(WINDOW_CYCLES - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Next timer value: wrap at the terminal count, hold at zero while disabled.
    always_comb begin
        timer_d = timer_q;
        if (!enable) begin
            timer_d = '0;
        end else if (timer_q == LAST) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Timer register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign tick = enable && (timer_q == LAST);

endmodule

// File: rtl/wheel_speed_meter.sv
// wheel_speed_meter: per-window signed displacement of the quadrature position count,
// reported as speed magnitude, direction, stopped and overspeed with a valid strobe.
// Optional build macro WHEEL_SPEED_AVG_EN: report a 4-window running average instead of
// the raw window delta (stopped detection always uses the raw delta).
module wheel_speed_meter
    import wheel_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int unsigned STALL_WINDOWS = 8,
    parameter int unsigned OVERSPEED_TH  = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count,
    input  logic               CW,
    input  logic               CWW,
    input  logic               enable,
    output logic [COUNT_W-1:0] speed,
    output logic               dir,
    output logic               stopped,
    output logic               overspeed,
    output logic               valid
);

    localparam logic [7:0] STALL_MAX = 8'(STALL_WINDOWS);

    logic tick;

    wheel_gate_timer #(
        .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_gate_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    wheel_state_e       state_q, state_d;
    logic [COUNT_W-1:0] prev_q, prev_d;
    logic [7:0]         stall_q, stall_d;
    logic [COUNT_W-1:0] speed_q, speed_d;
    logic               dir_q, dir_d;
    logic               stopped_q, stopped_d;
    logic               over_q, over_d;
    logic               valid_q, valid_d;

    delta_t             delta_raw;
    delta_t             delta_rep;
    logic [COUNT_W-1:0] mag;

    // Modular subtract gives the correct signed step across the 255->0 wrap.
    assign delta_raw = delta_t'(count - prev_q);

`ifdef WHEEL_SPEED_AVG_EN
    delta_t [3:0]      hist_q, hist_d;
    logic signed [9:0] sum_q, sum_d, sum_next;

    // Running sum slides by adding the newest delta and dropping the oldest history entry.
    assign sum_next  = sum_q + {{2{delta_raw[COUNT_W-1]}}, delta_raw}
                             - {{2{hist_q[3][COUNT_W-1]}}, hist_q[3]};
    assign delta_rep = delta_t'(sum_next >>> 2);
`else
    assign delta_rep = delta_raw;
`endif

    assign mag = abs_mag(delta_rep);

    // Next-state and report computation for the baseline / measure / report sequence.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        stall_d   = stall_q;
        speed_d   = speed_q;
        dir_d     = dir_q;
        stopped_d = stopped_q;
        over_d    = over_q;
        valid_d   = 1'b0;
`ifdef WHEEL_SPEED_AVG_EN
        hist_d    = hist_q;
        sum_d     = sum_q;
`endif
        if (!enable) begin
            state_d = S_INIT;
`ifdef WHEEL_SPEED_AVG_EN
            hist_d  = '0;
            sum_d   = '0;
`endif
        end else begin
            case (state_q)
                S_INIT: begin
`ifdef WHEEL_SPEED_AVG_EN
                    hist_d = '0;
                    sum_d  = '0;
`endif
                    if (tick) begin
                        prev_d  = count;
                        state_d = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (tick) begin
                        prev_d  = count;
                        state_d = S_REPORT;
                        valid_d = 1'b1;
                        speed_d = mag;
                        over_d  = (32'(mag) >= OVERSPEED_TH);
                        if (delta_rep > 0) begin
                            dir_d = 1'b1;
                        end else if (delta_rep < 0) begin
                            dir_d = 1'b0;
                        end else if (CW ^ CWW) begin
                            dir_d = CW;
                        end
                        // stopped stays set through further idle windows and only motion clears it
                        if (delta_raw == '0) begin
                            if (stall_q < STALL_MAX) begin
                                stall_d = stall_q + 1'b1;
                            end
                            stopped_d = stopped_q | (stall_d == STALL_MAX);
                        end else begin
                            stall_d   = '0;
                            stopped_d = 1'b0;
                        end
`ifdef WHEEL_SPEED_AVG_EN
                        hist_d = {hist_q[2:0], delta_raw};
                        sum_d  = sum_next;
`endif
                    end
                end
                S_REPORT: begin
                    state_d = S_MEASURE;
                end
                default: begin
                    state_d = S_INIT;
                end
            endcase
        end
    end

    // State and held result registers, all cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_INIT;
            prev_q    <= '0;
            stall_q   <= '0;
            speed_q   <= '0;
            dir_q     <= 1'b0;
            stopped_q <= 1'b1;
            over_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef WHEEL_SPEED_AVG_EN
            hist_q    <= '0;
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            stall_q   <= stall_d;
            speed_q   <= speed_d;
            dir_q     <= dir_d;
            stopped_q <= stopped_d;
            over_q    <= over_d;
            valid_q   <= valid_d;
`ifdef WHEEL_SPEED_AVG_EN
            hist_q    <= hist_d;
            sum_q     <= sum_d;
`endif
        end
    end

    assign speed     = speed_q;
    assign dir       = dir_q;
    assign stopped   = stopped_q;
    assign overspeed = over_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_wheel_speed_meter.sv
// tb_wheel_speed_meter: directed scoreboard bench for wheel_speed_meter with a 16-cycle window.
module tb_wheel_speed_meter;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] count;
    logic       CW;
    logic       CWW;
    logic       enable;
    logic [7:0] speed;
    logic       dir;
    logic       stopped;
    logic       overspeed;
    logic       valid;

    typedef struct {
        logic [7:0] speed;
        logic       dir;
        logic       stopped;
        logic       over;
        int         cyc;
    } exp_t;

    exp_t sbQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycleCnt   = 0;

    // 100 MHz bench clock
    always #5 clk = ~clk;

    // Free-running cycle index used to check when each valid strobe arrives
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    wheel_speed_meter #(
        .WINDOW_CYCLES (WIN),
        .STALL_WINDOWS (3),
        .OVERSPEED_TH  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .CW        (CW),
        .CWW       (CWW),
        .enable    (enable),
        .speed     (speed),
        .dir       (dir),
        .stopped   (stopped),
        .overspeed (overspeed),
        .valid     (valid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Expected report for the window about to be driven; valid lands on the first cycle of the next window
    task automatic pushExp(input logic [7:0] s, input logic d, input logic st, input logic ov);
        sbQ.push_back('{speed: s, dir: d, stopped: st, over: ov, cyc: cycleCnt + WIN});
    endtask

    // Drives one full window starting on a timer-zero cycle; count moves by stepAmt every stepEvery cycles
    task automatic applyStimulus(input int stepAmt, input int stepEvery, input int nSteps,
                                 input logic cwIn, input logic cwwIn);
        int done;
        done = 0;
        CW  = cwIn;
        CWW = cwwIn;
        for (int i = 0; i < WIN; i++) begin
            if ((((i + 1) % stepEvery) == 0) && (done < nSteps)) begin
                count = count + 8'(stepAmt);
                done++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetValues(input string phase);
        checkOutput({phase, "_speed"}, speed, 0);
        checkOutput({phase, "_dir"}, dir, 0);
        checkOutput({phase, "_stopped"}, stopped, 1);
        checkOutput({phase, "_overspeed"}, overspeed, 0);
        checkOutput({phase, "_valid"}, valid, 0);
    endtask

    // Scoreboard: every valid must match the oldest expected report, arriving on its expected cycle
    always @(negedge clk) begin
        exp_t e;
        if (valid !== 1'b0) begin
            if (sbQ.size() == 0) begin
                checkOutput("spurious_valid", valid, 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("valid_cycle", cycleCnt, e.cyc);
                checkOutput("speed", speed, e.speed);
                checkOutput("dir", dir, e.dir);
                checkOutput("stopped", stopped, e.stopped);
                checkOutput("overspeed", overspeed, e.over);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        count  = 8'd0;
        CW     = 1'b0;
        CWW    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset  = 1'b1;
        enable = 1'b1;

        // baseline window produces no report
        applyStimulus(0, 16, 0, 1'b0, 1'b0);

`ifdef WHEEL_SPEED_AVG_EN
        $display("[TB] averaging build: constant +8 per window");
        pushExp(8'd2, 1'b1, 1'b0, 1'b0); applyStimulus(1, 2, 8, 1'b1, 1'b0);
        pushExp(8'd4, 1'b1, 1'b0, 1'b0); applyStimulus(1, 2, 8, 1'b1, 1'b0);
        pushExp(8'd6, 1'b1, 1'b0, 1'b0); applyStimulus(1, 2, 8, 1'b1, 1'b0);
        pushExp(8'd8, 1'b1, 1'b0, 1'b0); applyStimulus(1, 2, 8, 1'b1, 1'b0);
        pushExp(8'd8, 1'b1, 1'b0, 1'b0); applyStimulus(1, 2, 8, 1'b1, 1'b0);
`else
        $display("[TB] static count, stopped held from reset");
        repeat (3) begin
            pushExp(8'd0, 1'b0, 1'b1, 1'b0);
            applyStimulus(0, 16, 0, 1'b0, 1'b0);
        end

        $display("[TB] clockwise +1 every 4 cycles");
        repeat (3) begin
            pushExp(8'd4, 1'b1, 1'b0, 1'b0);
            applyStimulus(1, 4, 4, 1'b1, 1'b0);
        end

        $display("[TB] jump to 250 then wrap through 255 to 4");
        pushExp(8'd18, 1'b0, 1'b0, 1'b1); applyStimulus(238, 16, 1, 1'b1, 1'b0);
        pushExp(8'd10, 1'b1, 1'b0, 1'b1); applyStimulus(1, 1, 10, 1'b1, 1'b0);

        $display("[TB] counter-clockwise -1 every 2 cycles, then halt");
        repeat (2) begin
            pushExp(8'd8, 1'b0, 1'b0, 1'b0);
            applyStimulus(-1, 2, 8, 1'b0, 1'b1);
        end
        pushExp(8'd0, 1'b0, 1'b0, 1'b0); applyStimulus(0, 16, 0, 1'b0, 1'b0);
        pushExp(8'd0, 1'b0, 1'b0, 1'b0); applyStimulus(0, 16, 0, 1'b0, 1'b0);
        pushExp(8'd0, 1'b0, 1'b1, 1'b0); applyStimulus(0, 16, 0, 1'b0, 1'b0);

        $display("[TB] direction hold and flag rule on zero delta");
        pushExp(8'd4, 1'b1, 1'b0, 1'b0); applyStimulus(1, 4, 4, 1'b1, 1'b0);
        pushExp(8'd0, 1'b1, 1'b0, 1'b0); applyStimulus(0, 16, 0, 1'b0, 1'b0);
        pushExp(8'd0, 1'b0, 1'b0, 1'b0); applyStimulus(0, 16, 0, 1'b0, 1'b1);

        $display("[TB] delta of -128");
        pushExp(8'd128, 1'b0, 1'b0, 1'b1); applyStimulus(-128, 16, 1, 1'b0, 1'b0);

        $display("[TB] reset mid-window, then enable cycled");
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #2;
        checkResetValues("midreset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        applyStimulus(0, 16, 0, 1'b1, 1'b0);
        pushExp(8'd4, 1'b1, 1'b0, 1'b0); applyStimulus(1, 4, 4, 1'b1, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", sbQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wheel_speed_meter.md
Name: wheel_speed_meter

Overview:
- Sits directly downstream of the quadrature wheel interface.
- Consumes its wrapping 8-bit position count and CW/CWW direction flags.
- Once per fixed gate window, computes signed displacement. Reports speed magnitude, direction, stopped and overspeed status, with a one-cycle valid strobe and held result registers for the control logic.

Parameters:
- WINDOW_CYCLES, 50000, clock cycles per gate window (1 ms at 50 MHz); legal range 4..2^20.
- STALL_WINDOWS, 8, consecutive zero-delta windows before stopped asserts; legal range 1..255.
- OVERSPEED_TH, 100, magnitude (counts/window) at or above which overspeed asserts.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- count  in  8  encoder position count, modulo 256; increments CW, decrements CCW.
- CW  in  1  wheel-interface clockwise direction flag.
- CWW  in  1  wheel-interface counter-clockwise direction flag.
- enable  in  1  measurement enable; when 0, timer and FSM idle.
- speed  out  8  |delta| of last window, unsigned, 0..128.
- dir  out  1  1 = clockwise, 0 = counter-clockwise.
- stopped  out  1  wheel judged stationary.
- overspeed  out  1  speed >= OVERSPEED_TH in last report.
- valid  out  1  one-cycle pulse when new results are loaded.

Behaviour:
- Reset (reset = 0, asynchronous):
  - speed = 0, dir = 0, stopped = 1, overspeed = 0, valid = 0.
  - timer = 0, prev = 0, stall counter = 0, FSM = S_INIT.
- Window timer:
  - Counts 0..WINDOW_CYCLES-1 while enable = 1.
  - Terminal tick asserts for one cycle at WINDOW_CYCLES-1, then timer wraps to 0.
- FSM:
  - S_INIT: on first tick, latch prev <= count; go to S_MEASURE; no valid. This discards the partial-baseline window.
  - S_MEASURE: on tick, compute delta = count - prev (8-bit modular subtract, read as two's complement); latch prev <= count; go to S_REPORT.
  - S_REPORT: single cycle.
    - Load speed, dir, overspeed, stopped.
    - Assert valid.
    - Return to S_MEASURE.
- Latency:
  - count is sampled on the tick cycle.
  - valid and outputs update on the following clock edge, i.e. 1 cycle after tick.
- Arithmetic:
  - speed = |delta|; delta = -128 gives speed = 128 (no saturation).
  - Movement beyond +/-127 counts per window aliases; window sizing is the integrator's responsibility.
- dir:
  - delta > 0 -> 1; delta < 0 -> 0.
  - delta = 0 -> dir = CW if CW xor CWW, else dir holds its previous value.
- stopped:
  - Stall counter increments on each zero-delta report and saturates at STALL_WINDOWS.
  - stopped = 1 when counter = STALL_WINDOWS.
  - Any nonzero delta clears the counter and stopped in the same report.
- overspeed: recomputed every report, never sticky.
- enable deassert:
  - Timer clears, FSM returns to S_INIT, outputs hold, valid = 0.
  - Re-enable restarts with a fresh baseline window.
- Wrap-around: count passing 255->0 CW yields a correct positive delta, e.g. prev 250, count 4 -> +10.
- Reset mid-window: asynchronous clear of everything; no valid is emitted for the aborted window.

Optional Feature:
- WHEEL_SPEED_AVG_EN defined:
  - Adds a 4-entry history of signed deltas.
  - Reported value is the running sum >>> 2 (arithmetic shift, 10-bit sum).
  - speed and dir derive from the averaged value; overspeed uses the averaged magnitude; stopped still uses raw delta.
  - History clears on reset and on entry to S_INIT; it fills with zeros, so the first 3 reports are attenuated.
- Not defined: raw per-window delta, no history registers.

Decomposition:
- Package wheel_pkg:
  - FSM state encoding S_INIT/S_MEASURE/S_REPORT.
  - COUNT_W = 8.
  - Default window constant for 50 MHz.
  - Signed delta typedef.
- Sub-module wheel_gate_timer:
  - Parameter WINDOW_CYCLES; inputs clk, reset, enable.
  - Output tick.
  - Reused later by other rate-measurement blocks.

Test Plan:
- Bench uses WINDOW_CYCLES = 16, STALL_WINDOWS = 3, OVERSPEED_TH = 10.
- Reset release, enable = 1, count static at 0 -> no valid in first window; valid every 16 cycles thereafter; speed = 0; stopped = 1 throughout.
- count stepping +1 every 4 cycles (CW = 1) -> steady speed = 4, dir = 1, stopped = 0 on first report, overspeed = 0.
- prev = 250, count advances to 4 within one window -> speed = 10, dir = 1, overspeed = 1.
- CCW steps -1 every 2 cycles -> speed = 8, dir = 0. Then motion halts -> stopped asserts exactly on the 3rd zero-delta report, dir holds 0.
- reset pulsed low mid-window, then enable dropped and raised -> all outputs at reset values immediately; the next valid comes only after a full baseline window plus a full measure window (33 cycles after re-enable).
- WHEEL_SPEED_AVG_EN, constant +8/window -> reported speeds 2, 4, 6, 8, 8.
